// File: rtl/uart_gpio_responder.sv
// uart_gpio_responder: command responder on the far end of a UART byte link.
// It takes bytes from the UART receive handshake and decodes 1- or 2-byte GPIO
// commands. It then updates the GPIO output/direction registers or samples the
// GPIO inputs, and answers every command with exactly one byte.
//
// Ports:
//   clk_50MHZ   in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   rx_rdy      in   1  receiver byte-available level
//   rx_data     in   8  received byte, valid while rx_rdy=1
//   rx_rdy_clr  out  1  one-cycle pulse acknowledging rx_data
//   tx_data     out  8  response byte, stable from tx_start until response done
//   tx_start    out  1  one-cycle transmit request
//   tx_busy     in   1  transmitter busy
//   gpio_in     in   8  asynchronous pad inputs
//   gpio_out    out  8  output data register
//   gpio_oe     out  8  direction register, 1 = drive
//   err_count   out  8  saturating count of NAK responses
//
// Commands: 'W' arg -> gpio_out=arg, ACK; 'D' arg -> gpio_oe=arg, ACK;
//           'R' -> synchronized gpio_in; '?' -> gpio_out; other -> NAK.
module uart_gpio_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic       clk_50MHZ,
  input  logic       reset,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_rdy_clr,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic [7:0] gpio_oe,
  output logic [7:0] err_count
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BYTE_W-1:0] ERR_MAX  = 8'hFF;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
  localparam logic [BYTE_W-1:0] CMD_DIR   = 8'h44;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;
  localparam logic [BYTE_W-1:0] CMD_QUERY = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ARG,
    S_CLR2,
    S_EXEC,
    S_TX_REQ,
    S_TX_HI,
    S_TX_LO
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BYTE_W-1:0] cmd;
  logic [BYTE_W-1:0] cmd_nxt;
  logic [BYTE_W-1:0] arg;
  logic [BYTE_W-1:0] arg_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [BYTE_W-1:0] gpio_s1;
  logic [BYTE_W-1:0] gpio_sync;

  logic              rx_rdy_clr_nxt;
  logic              tx_start_nxt;
  logic [BYTE_W-1:0] tx_data_nxt;
  logic [BYTE_W-1:0] gpio_out_nxt;
  logic [BYTE_W-1:0] gpio_oe_nxt;
  logic [BYTE_W-1:0] err_count_nxt;
  logic              nak;

  logic has_arg;
  logic arg_timeout;

  // Commands that need an argument byte before they can execute.
  assign has_arg = (cmd == CMD_WRITE) || (cmd == CMD_DIR);

  // Terminal count with no byte present; a byte on that same cycle still wins.
  assign arg_timeout = !rx_rdy && (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk_50MHZ) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (rx_rdy) state_nxt = S_CLR;
      S_CLR:    state_nxt = has_arg ? S_ARG : S_EXEC;
      S_ARG: begin
        if (rx_rdy) begin
          state_nxt = S_CLR2;
        end else if (arg_timeout) begin
          state_nxt = S_TX_REQ;
        end
      end
      S_CLR2:   state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_TX_REQ;
      S_TX_REQ: if (!tx_busy) state_nxt = S_TX_HI;
      S_TX_HI:  if (tx_busy) state_nxt = S_TX_LO;
      S_TX_LO:  if (!tx_busy) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything here lands in registers.
  always_comb begin
    cmd_nxt        = cmd;
    arg_nxt        = arg;
    cnt_nxt        = cnt;
    rx_rdy_clr_nxt = 1'b0;
    tx_start_nxt   = 1'b0;
    tx_data_nxt    = tx_data;
    gpio_out_nxt   = gpio_out;
    gpio_oe_nxt    = gpio_oe;
    nak            = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_rdy) begin
          cmd_nxt        = rx_data;
          rx_rdy_clr_nxt = 1'b1;
        end
      end
      S_CLR: begin
        cnt_nxt = '0;
      end
      S_ARG: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (rx_rdy) begin
          arg_nxt        = rx_data;
          rx_rdy_clr_nxt = 1'b1;
        end else if (arg_timeout) begin
          tx_data_nxt = NAK_BYTE;
          nak         = 1'b1;
        end
      end
      S_EXEC: begin
        case (cmd)
          CMD_WRITE: begin
            gpio_out_nxt = arg;
            tx_data_nxt  = ACK_BYTE;
          end
          CMD_DIR: begin
            gpio_oe_nxt = arg;
            tx_data_nxt = ACK_BYTE;
          end
          CMD_READ:  tx_data_nxt = gpio_sync;
          CMD_QUERY: tx_data_nxt = gpio_out;
          default: begin
            tx_data_nxt = NAK_BYTE;
            nak         = 1'b1;
          end
        endcase
      end
      S_TX_REQ: begin
        if (!tx_busy) tx_start_nxt = 1'b1;
      end
      default: begin
      end
    endcase

    err_count_nxt = (nak && (err_count != ERR_MAX)) ? err_count + 8'd1 : err_count;
  end

  // Output, command and synchronizer registers.
  always_ff @(posedge clk_50MHZ) begin
    if (reset) begin
      cmd        <= '0;
      arg        <= '0;
      cnt        <= '0;
      gpio_s1    <= '0;
      gpio_sync  <= '0;
      rx_rdy_clr <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      gpio_out   <= '0;
      gpio_oe    <= '0;
      err_count  <= '0;
    end else begin
      cmd        <= cmd_nxt;
      arg        <= arg_nxt;
      cnt        <= cnt_nxt;
      gpio_s1    <= gpio_in;
      gpio_sync  <= gpio_s1;
      rx_rdy_clr <= rx_rdy_clr_nxt;
      tx_start   <= tx_start_nxt;
      tx_data    <= tx_data_nxt;
      gpio_out   <= gpio_out_nxt;
      gpio_oe    <= gpio_oe_nxt;
      err_count  <= err_count_nxt;
    end
  end

endmodule

// File: tb/tb_uart_gpio_responder.sv
// Directed bench for uart_gpio_responder with a behavioural UART model
// (receiver byte queue and transmitter busy window) stepped one clock at a time.
module tb_uart_gpio_responder;

  localparam int unsigned TMO  = 100;
  localparam int          BUSY = 3;
  localparam int          WAIT_MAX = 400;

  logic       clk_50MHZ;
  logic       reset;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_rdy_clr;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic [7:0] gpio_oe;
  logic [7:0] err_count;

  uart_gpio_responder #(
    .TIMEOUT_CYCLES(TMO),
    .ACK_BYTE      (8'h06),
    .NAK_BYTE      (8'h15)
  ) dut (
    .clk_50MHZ (clk_50MHZ),
    .reset     (reset),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .rx_rdy_clr(rx_rdy_clr),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oe   (gpio_oe),
    .err_count (err_count)
  );

  initial clk_50MHZ = 1'b0;
  always #5 clk_50MHZ = ~clk_50MHZ;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] rxq[$];
  int         cyc = 0;
  int         load_cyc = 0;
  int         start_cyc = 0;
  int         clr_cnt = 0;
  int         start_cnt = 0;
  int         n_bytes = 0;
  int         n_cmds = 0;
  int         busy_left = 0;
  bit         got_resp = 0;
  logic [7:0] resp_byte = 8'h00;
  int         c0;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: the receiver drops rx_rdy the cycle after seeing rx_rdy_clr and
  // presents the next queued byte a cycle later; the transmitter captures
  // tx_data on tx_start and stays busy for BUSY cycles.
  task automatic tick();
    logic clr_prev;
    logic start_prev;
    clr_prev   = rx_rdy_clr;
    start_prev = tx_start;
    @(posedge clk_50MHZ);
    #1;
    cyc++;
    if (clr_prev === 1'b1) begin
      rx_rdy = 1'b0;
      clr_cnt++;
    end else if (!rx_rdy && rxq.size() > 0) begin
      rx_data  = rxq.pop_front();
      rx_rdy   = 1'b1;
      load_cyc = cyc;
    end
    if (start_prev === 1'b1) begin
      resp_byte = tx_data;
      got_resp  = 1'b1;
      start_cnt++;
      tx_busy   = 1'b1;
      busy_left = BUSY;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
    if (tx_start === 1'b1) start_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
    n_bytes++;
  endtask

  task automatic wait_resp(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    got_resp = 1'b0;
    while (!got_resp && n < WAIT_MAX) begin
      tick();
      n++;
    end
    n_cmds++;
    chk8({tag, "_arrived"}, {7'd0, got_resp}, 8'h01);
    chk8(tag, resp_byte, exp);
  endtask

  task automatic wait_clr(input string tag);
    int n;
    n = 0;
    while (rx_rdy_clr !== 1'b1 && n < WAIT_MAX) begin
      tick();
      n++;
    end
    chk8({tag, "_clr_seen"}, {7'd0, rx_rdy_clr}, 8'h01);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (tx_start !== 1'b1 && n < WAIT_MAX) begin
      tick();
      n++;
    end
    chk8({tag, "_start_seen"}, {7'd0, tx_start}, 8'h01);
  endtask

  task automatic chk_reset(input string tag);
    chk8({tag, "_rx_rdy_clr"}, {7'd0, rx_rdy_clr}, 8'h00);
    chk8({tag, "_tx_start"},   {7'd0, tx_start},   8'h00);
    chk8({tag, "_tx_data"},    tx_data,            8'h00);
    chk8({tag, "_gpio_out"},   gpio_out,           8'h00);
    chk8({tag, "_gpio_oe"},    gpio_oe,            8'h00);
    chk8({tag, "_err_count"},  err_count,          8'h00);
  endtask

  initial begin
    reset   = 1'b1;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    tx_busy = 1'b0;
    gpio_in = 8'h00;
    idle(3);
    chk_reset("por");
    reset = 1'b0;
    idle(2);

    // Write then query; the write is visible before the ACK goes out.
    push(8'h57);
    push(8'hA5);
    wait_start("w_a5");
    chk8("w_a5_gpio_out_before_ack", gpio_out, 8'hA5);
    wait_resp("w_a5_resp", 8'h06);
    idle(10);
    push(8'h3F);
    wait_resp("q_resp", 8'hA5);
    chk_int("q_latency", start_cyc - load_cyc, 4);

    // Direction register write leaves gpio_out alone.
    push(8'h44);
    push(8'h0F);
    wait_resp("d_resp", 8'h06);
    chk8("d_gpio_oe", gpio_oe, 8'h0F);
    chk8("d_gpio_out", gpio_out, 8'hA5);

    // Read through the 2-flop synchronizer: a change one cycle before EXEC is not seen.
    gpio_in = 8'h3C;
    idle(10);
    push(8'h52);
    wait_clr("r1");
    gpio_in = 8'hC3;
    wait_resp("r1_resp", 8'h3C);
    idle(4);
    push(8'h52);
    wait_resp("r2_resp", 8'hC3);

    // Unknown command.
    push(8'h00);
    wait_resp("unk_resp", 8'h15);
    chk8("unk_err", err_count, 8'h01);

    // Argument timeout: 100 cycles in ARG, then NAK; the late byte is a new command.
    idle(10);
    push(8'h57);
    wait_clr("tmo");
    c0 = cyc;
    wait_resp("tmo_resp", 8'h15);
    chk_int("tmo_cycles", start_cyc - c0, 102);
    chk8("tmo_gpio_out", gpio_out, 8'hA5);
    chk8("tmo_err", err_count, 8'h02);
    push(8'hA5);
    wait_resp("late_resp", 8'h15);
    chk8("late_err", err_count, 8'h03);

    // Saturation of err_count at FF.
    for (int i = 0; i < 251; i++) begin
      push(8'hA0 + 8'(i % 16));
      wait_resp("sat_a", 8'h15);
    end
    chk8("err_fe", err_count, 8'hFE);
    push(8'hB7);
    wait_resp("sat_b", 8'h15);
    chk8("err_ff", err_count, 8'hFF);
    for (int i = 0; i < 48; i++) begin
      push(8'hC0 + 8'(i % 16));
      wait_resp("sat_c", 8'h15);
    end
    chk8("err_hold_ff", err_count, 8'hFF);

    // One rx_rdy_clr per consumed byte and one tx_start per command.
    idle(10);
    chk_int("clr_per_byte", clr_cnt, n_bytes);
    chk_int("start_per_cmd", start_cnt, n_cmds);

    // Reset while waiting for the argument byte.
    push(8'h57);
    wait_clr("rst_arg");
    idle(3);
    reset = 1'b1;
    tick();
    chk_reset("rst_arg");
    reset = 1'b0;
    push(8'h57);
    push(8'h11);
    wait_start("after_rst_arg");
    chk8("after_rst_arg_gpio_out", gpio_out, 8'h11);
    wait_resp("after_rst_arg_resp", 8'h06);

    // Reset in TX_HI (tx_start just issued).
    idle(10);
    push(8'h3F);
    wait_start("rst_txhi");
    reset = 1'b1;
    tick();
    chk_reset("rst_txhi");
    reset = 1'b0;
    push(8'h57);
    push(8'h11);
    wait_resp("after_rst_txhi_resp", 8'h06);
    chk8("after_rst_txhi_gpio_out", gpio_out, 8'h11);
    chk8("after_rst_txhi_err", err_count, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
